// File: rtl/codec_init_pkg.sv
// Shared definitions for the codec register-initialisation sequencer.
// Holds the FSM state type, the codec device address and the register table.
// Table entries are {reg[6:0], data[8:0]} pairs, sent as two I2C bytes.
package codec_init_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PWR,
        ISSUE,
        WAIT_DONE,
        DONE,
        ERROR
    } state_t;

    localparam int         NUM_REGS   = 9;
    localparam logic [6:0] CODEC_ADDR = 7'h1A;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } reg_entry_t;

    // Write order matters: reset the codec first (R15), leave power-down
    // configuration before the interface format, and activate (R9) last so
    // the codec only starts running once fully configured.
    function automatic reg_entry_t table_entry(input logic [3:0] index);
        reg_entry_t entry;
        case (index)
            4'd0:    entry = '{addr: 7'd15, data: 9'h000};
            4'd1:    entry = '{addr: 7'd6,  data: 9'h010};
            4'd2:    entry = '{addr: 7'd0,  data: 9'h017};
            4'd3:    entry = '{addr: 7'd1,  data: 9'h017};
            4'd4:    entry = '{addr: 7'd4,  data: 9'h012};
            4'd5:    entry = '{addr: 7'd5,  data: 9'h000};
            4'd6:    entry = '{addr: 7'd7,  data: 9'h002};
            4'd7:    entry = '{addr: 7'd8,  data: 9'h000};
            4'd8:    entry = '{addr: 7'd9,  data: 9'h001};
            default: entry = '{addr: 7'd0,  data: 9'h000};
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Purpose: maps a table index to the two I2C payload bytes of that entry.
// Latency: combinational. Backpressure: none (pure lookup).
// Ports: index[3:0] in; byte0 = {reg[6:0], data[8]}, byte1 = data[7:0] out.
//        Indices past the table return zero bytes.
module codec_init_rom
    import codec_init_pkg::*;
(
    input  logic [3:0] index,
    output logic [7:0] byte0,
    output logic [7:0] byte1
);

    reg_entry_t entry;

    always_comb begin
        entry = table_entry(index);
        byte0 = {entry.addr, entry.data[8]};
        byte1 = entry.data[7:0];
    end

endmodule

// File: rtl/codec_init_seq.sv
// Purpose: after go, waits POWERUP_WAIT cycles then writes the codec register
//          table over an external I2C master, one entry per transaction.
// Latency: first i2c_start 5 cycles after go with POWERUP_WAIT=4 (go cycle +
//          POWERUP_WAIT countdown + one ISSUE cycle); outputs are registered.
// Backpressure: holds in ISSUE while i2c_busy=1; each write waits for
//          i2c_done, bounded by a TIMEOUT_CYCLES watchdog.
// Ports: clk, reset (sync, active-high); go; i2c_busy/i2c_done/i2c_nack from
//        the master; i2c_start, i2c_dev_addr, i2c_byte0/1 to the master;
//        cur_index, init_done, init_err, audio_en status.
// Option: define CODEC_INIT_RETRY_EN to re-issue a failed entry up to
//        MAX_RETRY times before giving up; otherwise any failure is fatal.
module codec_init_seq
    import codec_init_pkg::*;
#(
    parameter int unsigned POWERUP_WAIT   = 12288,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    output logic       i2c_start,
    output logic [6:0] i2c_dev_addr,
    output logic [7:0] i2c_byte0,
    output logic [7:0] i2c_byte1,
    output logic [3:0] cur_index,
    output logic       init_done,
    output logic       init_err,
    output logic       audio_en
);

    localparam int WW = (POWERUP_WAIT   < 2) ? 1 : $clog2(POWERUP_WAIT + 1);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] LAST_INDEX = 4'(NUM_REGS - 1);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] wdog_cnt;
    logic [7:0]    rom_byte0;
    logic [7:0]    rom_byte1;
    logic          xfer_ok;
    logic          xfer_fail;
    logic          can_retry;

`ifdef CODEC_INIT_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;
`endif

    assign i2c_dev_addr = CODEC_ADDR;

    codec_init_rom u_rom (
        .index (cur_index),
        .byte0 (rom_byte0),
        .byte1 (rom_byte1)
    );

    // i2c_done wins over a watchdog expiry landing in the same cycle, so a
    // slow-but-successful transaction is never misreported as a timeout.
    always_comb begin
        xfer_ok   = (state == WAIT_DONE) && i2c_done && !i2c_nack;
        xfer_fail = (state == WAIT_DONE) &&
                    ((i2c_done && i2c_nack) || (!i2c_done && wdog_cnt == '0));
`ifdef CODEC_INIT_RETRY_EN
        can_retry = (retry_cnt < RW'(MAX_RETRY));
`else
        can_retry = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            wdog_cnt  <= '0;
            i2c_start <= 1'b0;
            i2c_byte0 <= '0;
            i2c_byte1 <= '0;
            cur_index <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            audio_en  <= 1'b0;
`ifdef CODEC_INIT_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            // i2c_start is a one-cycle strobe; only ISSUE raises it.
            i2c_start <= 1'b0;

            case (state)
                IDLE, DONE, ERROR: begin
                    if (go) begin
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        audio_en  <= 1'b0;
                        cur_index <= '0;
`ifdef CODEC_INIT_RETRY_EN
                        retry_cnt <= '0;
`endif
                        wait_cnt  <= WW'(POWERUP_WAIT - 1);
                        state     <= WAIT_PWR;
                    end
                end

                WAIT_PWR: begin
                    if (wait_cnt == '0) begin
                        state <= ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                ISSUE: begin
                    // Bytes are latched here and left untouched until the
                    // next ISSUE, keeping them stable for the whole transfer.
                    if (!i2c_busy) begin
                        i2c_start <= 1'b1;
                        i2c_byte0 <= rom_byte0;
                        i2c_byte1 <= rom_byte1;
                        wdog_cnt  <= TW'(TIMEOUT_CYCLES - 1);
                        state     <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (xfer_ok) begin
                        if (cur_index == LAST_INDEX) begin
                            init_done <= 1'b1;
                            audio_en  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cur_index <= cur_index + 4'd1;
`ifdef CODEC_INIT_RETRY_EN
                            retry_cnt <= '0;
`endif
                            state     <= ISSUE;
                        end
                    end else if (xfer_fail) begin
                        if (can_retry) begin
`ifdef CODEC_INIT_RETRY_EN
                            retry_cnt <= retry_cnt + 1'b1;
`endif
                            state     <= ISSUE;
                        end else begin
                            init_err <= 1'b1;
                            audio_en <= 1'b0;
                            state    <= ERROR;
                        end
                    end else begin
                        wdog_cnt <= wdog_cnt - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_init_seq.sv
// Self-checking bench for codec_init_seq (POWERUP_WAIT=4, TIMEOUT_CYCLES=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected bytes come from a hand-computed table of the codec register list.
`timescale 1ns/1ps
module tb_codec_init_seq;

    localparam int PW = 4;
    localparam int TO = 8;
    localparam int MR = 3;
`ifdef CODEC_INIT_RETRY_EN
    localparam int EXP_NACK_STARTS = MR + 1;
`else
    localparam int EXP_NACK_STARTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       i2c_busy;
    logic       i2c_done;
    logic       i2c_nack;
    logic       i2c_start;
    logic [6:0] i2c_dev_addr;
    logic [7:0] i2c_byte0;
    logic [7:0] i2c_byte1;
    logic [3:0] cur_index;
    logic       init_done;
    logic       init_err;
    logic       audio_en;

    codec_init_seq #(
        .POWERUP_WAIT   (PW),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRY      (MR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .i2c_busy     (i2c_busy),
        .i2c_done     (i2c_done),
        .i2c_nack     (i2c_nack),
        .i2c_start    (i2c_start),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_byte0    (i2c_byte0),
        .i2c_byte1    (i2c_byte1),
        .cur_index    (cur_index),
        .init_done    (init_done),
        .init_err     (init_err),
        .audio_en     (audio_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;

    vec_t rom_vec [9];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Looks for i2c_start at the current falling edge first, then waits.
    task automatic wait_start(input int limit, output bit found);
        found = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (i2c_start) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called at the falling edge where i2c_start is seen. Answers with an
    // i2c_done pulse driven 'delay' falling edges later.
    task automatic serve(input int idx, input bit nack, input int delay);
        chk($sformatf("idx%0d_byte0", idx), i2c_byte0, rom_vec[idx].b0);
        chk($sformatf("idx%0d_byte1", idx), i2c_byte1, rom_vec[idx].b1);
        chk($sformatf("idx%0d_cur_index", idx), cur_index, rom_vec[idx].idx);
        tick();
        chk($sformatf("idx%0d_start_width", idx), i2c_start, 1'b0);
        for (int k = 1; k < delay; k++) tick();
        chk($sformatf("idx%0d_byte0_stable", idx), i2c_byte0, rom_vec[idx].b0);
        chk($sformatf("idx%0d_byte1_stable", idx), i2c_byte1, rom_vec[idx].b1);
        i2c_done = 1'b1;
        i2c_nack = nack;
        tick();
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
    endtask

    task automatic expect_serve(input int idx, input bit nack, input int delay);
        bit found;
        wait_start(40, found);
        chk($sformatf("idx%0d_start_seen", idx), found, 1'b1);
        if (found) serve(idx, nack, delay);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int bad;
        int starts;

        // {index, byte0 = {reg, data[8]}, byte1 = data[7:0]}
        rom_vec[0] = '{4'd0, 8'h1E, 8'h00};  // R15 = 0x000
        rom_vec[1] = '{4'd1, 8'h0C, 8'h10};  // R6  = 0x010
        rom_vec[2] = '{4'd2, 8'h00, 8'h17};  // R0  = 0x017
        rom_vec[3] = '{4'd3, 8'h02, 8'h17};  // R1  = 0x017
        rom_vec[4] = '{4'd4, 8'h08, 8'h12};  // R4  = 0x012
        rom_vec[5] = '{4'd5, 8'h0A, 8'h00};  // R5  = 0x000
        rom_vec[6] = '{4'd6, 8'h0E, 8'h02};  // R7  = 0x002
        rom_vec[7] = '{4'd7, 8'h10, 8'h00};  // R8  = 0x000
        rom_vec[8] = '{4'd8, 8'h12, 8'h01};  // R9  = 0x001

        reset = 1'b1; go = 1'b0; i2c_busy = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
        repeat (3) tick();
        chk("rst_start", i2c_start, 1'b0);
        chk("rst_byte0", i2c_byte0, 8'h00);
        chk("rst_byte1", i2c_byte1, 8'h00);
        chk("rst_cur_index", cur_index, 4'd0);
        chk("rst_flags", {init_done, init_err, audio_en}, 3'b000);
        chk("rst_dev_addr", i2c_dev_addr, 7'h1A);
        reset = 1'b0;
        tick();

        // Nominal run; a second go during the power-up wait must be ignored.
        pulse_go();                 // now one edge after go was sampled
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        chk("nom_no_early_start", i2c_start, 1'b0);
        tick();
        chk("nom_first_start_latency", i2c_start, 1'b1);
        for (int i = 0; i < 9; i++) expect_serve(i, 1'b0, 3);
        tick();
        chk("nom_init_done", init_done, 1'b1);
        chk("nom_audio_en", audio_en, 1'b1);
        chk("nom_init_err", init_err, 1'b0);
        chk("nom_final_index", cur_index, 4'd8);
        i2c_done = 1'b1;            // stray done in DONE is ignored
        tick();
        i2c_done = 1'b0;
        tick();
        chk("nom_stray_done_flags", {init_done, audio_en, i2c_start}, 3'b110);

        // Busy stall: 20 cycles in ISSUE with busy held.
        pulse_go();
        i2c_busy = 1'b1;
        bad = 0;
        for (int k = 2; k <= 25; k++) begin
            tick();
            if (i2c_start) bad++;
        end
        i2c_busy = 1'b0;
        chk("busy_no_start", bad, 0);
        tick();
        chk("busy_start_when_free", i2c_start, 1'b1);
        for (int i = 0; i < 5; i++) expect_serve(i, 1'b0, 2);

        // Reset while index 5 is in flight.
        wait_start(40, found);
        chk("rst5_start_seen", found, 1'b1);
        chk("rst5_index", cur_index, 4'd5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst5_outputs", {i2c_start, i2c_byte0, i2c_byte1, cur_index}, 21'h0);
        chk("rst5_flags", {init_done, init_err, audio_en}, 3'b000);
        chk("rst5_dev_addr", i2c_dev_addr, 7'h1A);
        i2c_done = 1'b1;            // late done from the aborted transfer
        tick();
        i2c_done = 1'b0;
        chk("rst5_late_done_ignored", {i2c_start, cur_index, init_done, init_err}, 7'h0);
        pulse_go();
        repeat (4) tick();
        chk("rst5_restart_no_early", i2c_start, 1'b0);
        tick();
        chk("rst5_restart_latency", i2c_start, 1'b1);
        serve(0, 1'b0, 2);

        // NACK forever on index 0.
        do_reset();
        pulse_go();
        starts = 0;
        for (int a = 0; a < 8; a++) begin
            wait_start(40, found);
            if (!found) break;
            starts++;
            serve(0, 1'b1, 2);
        end
        chk("nack0_start_count", starts, EXP_NACK_STARTS);
        chk("nack0_flags", {init_done, init_err, audio_en}, 3'b010);
        chk("nack0_index", cur_index, 4'd0);

        // NACK twice on index 2, then ACK (go accepted from ERROR).
        pulse_go();
        expect_serve(0, 1'b0, 2);
        expect_serve(1, 1'b0, 2);
        starts = 0;
        found = 1'b1;
        while (found && starts < 6) begin
            wait_start(40, found);
            if (found) begin
                if (cur_index != 4'd2) break;
                starts++;
                serve(2, starts <= 2, 2);
            end
        end
`ifdef CODEC_INIT_RETRY_EN
        chk("nack2_start_count", starts, 3);
        for (int i = 3; i < 9; i++) expect_serve(i, 1'b0, 2);
        tick();
        chk("nack2_done_flags", {init_done, init_err, audio_en}, 3'b101);
`else
        chk("nack2_start_count", starts, 1);
        chk("nack2_err_flags", {init_done, init_err, audio_en}, 3'b010);
        chk("nack2_index", cur_index, 4'd2);
`endif

        // Timeout: done on the expiry cycle is a success; silence is a failure.
        pulse_go();
        expect_serve(0, 1'b0, TO - 1);
        wait_start(40, found);
        chk("to_same_cycle_ack_advances", found, 1'b1);
        chk("to_same_cycle_ack_index", cur_index, 4'd1);
        repeat (TO - 1) tick();
        chk("to_not_early", init_err, 1'b0);
        tick();
`ifdef CODEC_INIT_RETRY_EN
        chk("to_retry_no_err", init_err, 1'b0);
        wait_start(40, found);
        chk("to_retry_start", found, 1'b1);
        chk("to_retry_index", cur_index, 4'd1);
`else
        chk("to_expired_err", {init_err, audio_en}, 2'b10);
        chk("to_expired_index", cur_index, 4'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/codec_init_seq.md
CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 The block SHALL have parameter POWERUP_WAIT, default 12288, meaning the number of cycles to wait after go before the first write (1 ms at 12.288 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum cycles to wait for i2c_done per write.
REQ-003 The block SHALL have parameter MAX_RETRY, default 3, meaning the number of re-issues allowed per entry after a NACK or timeout.
REQ-004 clk  input  1  slow clock (12.288 MHz domain); sole clock.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 go  input  1  single-cycle request to start or restart the sequence.
REQ-007 i2c_busy  input  1  the I2C master is mid-transaction.
REQ-008 i2c_done  input  1  single-cycle pulse marking the end of a transaction.
REQ-009 i2c_nack  input  1  ACK status, valid only with i2c_done; 1 means NACK.
REQ-010 i2c_start  output  1  single-cycle write request to the I2C master.
REQ-011 i2c_dev_addr  output  7  codec device address, constant 7'h1A.
REQ-012 i2c_byte0, i2c_byte1  output  8 each  {reg[6:0],data[8]} and data[7:0].
REQ-013 cur_index  output  4  ROM entry in progress, for seven-seg display.
REQ-014 init_done, init_err, audio_en  output  1 each  status flags; audio_en gates the I2S controller.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_PWR, ISSUE, WAIT_DONE, DONE and ERROR.
REQ-016 In IDLE, DONE or ERROR, go SHALL clear init_done, init_err, audio_en, cur_index and the retry count, load the wait counter with POWERUP_WAIT-1, and enter WAIT_PWR.
REQ-017 go SHALL be ignored in WAIT_PWR, ISSUE and WAIT_DONE.
REQ-018 WAIT_PWR SHALL decrement the wait counter and enter ISSUE in the cycle after the counter reads 0.
REQ-019 In ISSUE with i2c_busy=0, the block SHALL pulse i2c_start for exactly one cycle with byte0 and byte1 taken from ROM[cur_index], then enter WAIT_DONE.
REQ-020 In ISSUE with i2c_busy=1, the block SHALL hold in ISSUE with i2c_start=0.
REQ-021 i2c_byte0 and i2c_byte1 SHALL remain stable from the i2c_start cycle until i2c_done.
REQ-022 On entry to WAIT_DONE, the watchdog SHALL load TIMEOUT_CYCLES-1 and decrement each cycle.
REQ-023 On i2c_done with i2c_nack=0, if cur_index==NUM_REGS-1 the block SHALL enter DONE; otherwise it SHALL increment cur_index, clear the retry count and enter ISSUE.
REQ-024 A failure SHALL be either i2c_done with i2c_nack=1 or watchdog expiry without i2c_done.
REQ-025 If i2c_done and watchdog expiry occur in the same cycle, i2c_done SHALL take precedence.
REQ-026 Retry behaviour on a failure SHALL follow REQ-033 and REQ-034.
REQ-027 While in DONE, init_done and audio_en SHALL be 1.
REQ-028 While in ERROR, init_err SHALL be 1 and audio_en SHALL be 0.
REQ-029 cur_index SHALL hold its final value in both DONE and ERROR.
REQ-030 i2c_done pulses outside WAIT_DONE SHALL be ignored.
REQ-031 Entry count is fixed: NUM_REGS=9, and cur_index SHALL never exceed 8.

Reset
REQ-032 When reset=1 at a clock edge, the block SHALL enter IDLE and zero all outputs, counters and the retry count, overriding any in-flight transaction; i2c_dev_addr is the only exception and SHALL stay constant 7'h1A.

Configuration
REQ-033 With CODEC_INIT_RETRY_EN defined, on a failure with retry count < MAX_RETRY the block SHALL increment the retry count and return to ISSUE for the same cur_index; a failure at MAX_RETRY SHALL enter ERROR.
REQ-034 Without CODEC_INIT_RETRY_EN, any failure SHALL enter ERROR immediately, and the retry counter SHALL be absent.

Structure
REQ-035 Package codec_init_pkg SHALL hold the state enum, NUM_REGS, CODEC_ADDR=7'h1A and the 9-entry table of {reg[6:0],data[8:0]} pairs.
REQ-036 Table order SHALL be: R15=0x000, R6=0x010, R0=0x017, R1=0x017, R4=0x012, R5=0x000, R7=0x002, R8=0x000, R9=0x001.
REQ-037 Sub-module codec_init_rom SHALL map index[3:0] combinationally to byte0 and byte1 using the table.

Verification
REQ-038 Nominal run (POWERUP_WAIT=4, always-ACK model): go -> first i2c_start 5 cycles later, nine starts with byte0/byte1 = 0x1E/0x00 first and 0x12/0x01 last, then init_done=1 and audio_en=1.
REQ-039 Busy stall: hold i2c_busy=1 for 20 cycles in ISSUE -> no i2c_start; start occurs in the first cycle busy=0.
REQ-040 NACK retry (macro defined): NACK on index 2 twice, then ACK -> three starts with byte0=0x00 and byte1=0x17, then the sequence continues and init_done=1.
REQ-041 NACK exhausted or macro off: NACK always on index 0 -> 4 starts with the macro (1 without), then init_err=1, cur_index=0, audio_en=0.
REQ-042 Timeout (TIMEOUT_CYCLES=8): no i2c_done -> failure after 8 cycles; a same-cycle i2c_done with ACK is accepted as success.
REQ-043 Reset mid-WAIT_DONE at index 5 -> next cycle IDLE with all outputs 0; a later go restarts from index 0 after the power-up wait.
